// File: rtl/gate_vector_checker.sv
// Drives the four 2-input vectors into an external gate block and checks its
// seven gate outputs against the truth table, with a configurable response latency.
module gate_vector_checker #(
  parameter int RESP_LAT = 0,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       y_in,
  output logic             a_out,
  output logic             b_out,
  output logic             stim_valid,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [6:0]       fail_mask
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] LAT = 4'(RESP_LAT);

  state_t     state, state_next;
  logic [3:0] lat_cnt;
  logic [6:0] expected;
  logic [6:0] diff;
  logic       sample;
  logic       err_full;

  // Bit order: and, or, not_b, nand, nor, xor, xnor
  always_comb begin
    expected = 7'b0000000;
    case (vec_idx)
      2'd0: expected = 7'b0011101;
      2'd1: expected = 7'b0101010;
      2'd2: expected = 7'b0111010;
      2'd3: expected = 7'b1100001;
      default: expected = 7'b0000000;
    endcase
  end

  // Case inequality so an undriven or unknown response bit counts as a mismatch
  always_comb begin
    diff = 7'b0000000;
    for (int i = 0; i < 7; i++) begin
      diff[i] = (y_in[i] !== expected[i]);
    end
  end

  assign sample   = (state == DRIVE) && (lat_cnt == LAT);
  assign err_full = (err_cnt == {ERR_W{1'b1}});

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      if (sample && (vec_idx == 2'd3)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      stim_valid <= 1'b0;
      vec_idx    <= 2'd0;
      lat_cnt    <= 4'd0;
      err_cnt    <= '0;
      fail_mask  <= 7'b0000000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            stim_valid <= 1'b1;
            vec_idx    <= 2'd0;
            lat_cnt    <= 4'd0;
            err_cnt    <= '0;
            fail_mask  <= 7'b0000000;
          end
        end
        DRIVE: begin
          if (sample) begin
            fail_mask <= fail_mask | diff;
            if ((|diff) && !err_full) err_cnt <= err_cnt + 1'b1;
            // The next vector goes out on the sampling edge itself, so there is no gap cycle
            if (vec_idx != 2'd3) begin
              vec_idx          <= vec_idx + 2'd1;
              {a_out, b_out}   <= vec_idx + 2'd1;
              lat_cnt          <= 4'd0;
            end else begin
              stim_valid <= 1'b0;
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == DRIVE);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench: three checker instances (latency 0, latency 2, 2-bit error counter)
// each driving a behavioural gate block with selectable faults.
module tb_gate_vector_checker;

  typedef struct {
    int         id;
    logic [7:0] err;
    logic [6:0] mask;
    logic       pass;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       start_v;
  logic [2:0][6:0]  y_v;
  logic [2:0]       a_v, b_v, sv_v, busy_v, done_v, pass_v;
  logic [2:0][1:0]  vi_v;
  logic [2:0][7:0]  err_v;
  logic [2:0][6:0]  mask_v;
  int               fmode [3];
  exp_t             sb [$];
  int               n_checks = 0;
  int               n_fails  = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] gate_ref(input logic a, input logic b);
    return {a & b, a | b, ~b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  // Mode 0 correct, 1 xor output stuck at 0, 2 every output inverted
  function automatic logic [6:0] gate_dut(input logic a, input logic b, input int mode);
    logic [6:0] y;
    y = gate_ref(a, b);
    if (mode == 1) y[1] = 1'b0;
    if (mode == 2) y = ~y;
    return y;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 2 : 0;
    localparam int EW  = (g == 2) ? 2 : 8;
    logic [EW-1:0] err;

    gate_vector_checker #(.RESP_LAT(LAT), .ERR_W(EW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[g]),
      .y_in       (y_v[g]),
      .a_out      (a_v[g]),
      .b_out      (b_v[g]),
      .stim_valid (sv_v[g]),
      .vec_idx    (vi_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .pass       (pass_v[g]),
      .err_cnt    (err),
      .fail_mask  (mask_v[g])
    );
    assign err_v[g] = 8'(err);

    // The latency-2 instance sees a gate block with two register stages
    if (g == 1) begin : g_pipe
      logic [6:0] d1, d2;
      always @(posedge clk) begin
        d1 <= gate_dut(a_v[g], b_v[g], fmode[g]);
        d2 <= d1;
      end
      assign y_v[g] = d2;
    end else begin : g_comb
      assign y_v[g] = gate_dut(a_v[g], b_v[g], fmode[g]);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_expected(input int id);
    exp_t       e;
    logic [6:0] d;
    logic [1:0] v;
    int         errmax;
    errmax = (id == 2) ? 3 : 255;
    e.id   = id;
    e.err  = 8'd0;
    e.mask = 7'd0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      d = gate_dut(v[1], v[0], fmode[id]) ^ gate_ref(v[1], v[0]);
      e.mask = e.mask | d;
      if ((|d) && (int'(e.err) < errmax)) e.err = e.err + 8'd1;
    end
    e.pass = (e.err == 8'd0);
    sb.push_back(e);
  endtask

  task automatic check_reset_state(input int id, input string tag);
    checkOutput({tag, "_a"},    a_v[id],    0);
    checkOutput({tag, "_b"},    b_v[id],    0);
    checkOutput({tag, "_sv"},   sv_v[id],   0);
    checkOutput({tag, "_vi"},   vi_v[id],   0);
    checkOutput({tag, "_busy"}, busy_v[id], 0);
    checkOutput({tag, "_done"}, done_v[id], 0);
    checkOutput({tag, "_pass"}, pass_v[id], 0);
    checkOutput({tag, "_err"},  err_v[id],  0);
    checkOutput({tag, "_mask"}, mask_v[id], 0);
  endtask

  // One full run: push the expected result, pulse start, follow the vectors, then pop and compare
  task automatic applyStimulus(input int id, input bit mid_start);
    int   lat;
    int   k;
    int   exp_vi;
    exp_t e;
    lat = (id == 1) ? 2 : 0;
    push_expected(id);
    @(negedge clk); start_v[id] = 1'b1;
    @(negedge clk); start_v[id] = 1'b0;
    k = 0;
    while (done_v[id] !== 1'b1 && k < 100) begin
      exp_vi = k / (lat + 1);
      checkOutput("busy", busy_v[id], 1);
      checkOutput("stim_valid", sv_v[id], 1);
      checkOutput("vec_idx", vi_v[id], exp_vi);
      checkOutput("a_out", a_v[id], (exp_vi >> 1) & 1);
      checkOutput("b_out", b_v[id], exp_vi & 1);
      checkOutput("pass_low", pass_v[id], 0);
      if (k == 0) begin
        checkOutput("err_clear", err_v[id], 0);
        checkOutput("mask_clear", mask_v[id], 0);
      end
      if (mid_start && k == 1) start_v[id] = 1'b1;
      if (mid_start && k == 2) start_v[id] = 1'b0;
      @(negedge clk);
      k++;
    end
    start_v[id] = 1'b0;
    checkOutput("run_len", k, 4 * (lat + 1));
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      checkOutput("sb_id", id, e.id);
      repeat (3) begin
        checkOutput("done", done_v[id], 1);
        checkOutput("err_cnt", err_v[id], e.err);
        checkOutput("fail_mask", mask_v[id], e.mask);
        checkOutput("pass", pass_v[id], e.pass);
        checkOutput("done_sv", sv_v[id], 0);
        checkOutput("done_busy", busy_v[id], 0);
        checkOutput("done_vi", vi_v[id], 3);
        checkOutput("done_ab", {a_v[id], b_v[id]}, 2'b11);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    rst_n   = 1'b0;
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) fmode[i] = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_state(i, "reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_release", busy_v[0], 0);

    $display("[TB] latency 0, correct gate block");
    applyStimulus(0, 0);

    $display("[TB] latency 2, pipelined gate block");
    applyStimulus(1, 0);

    $display("[TB] xor stuck at 0, start pulsed during the run");
    fmode[0] = 1;
    applyStimulus(0, 1);

    $display("[TB] restart from DONE with a correct gate block");
    fmode[0] = 0;
    applyStimulus(0, 0);

    $display("[TB] 2-bit error counter with every output inverted");
    fmode[2] = 2;
    applyStimulus(2, 0);

    $display("[TB] reset in the middle of a run");
    fmode[0] = 1;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    k = 0;
    while (vi_v[0] !== 2'd2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("reach_vec2", vi_v[0], 2);
    rst_n = 1'b0;
    #1;
    check_reset_state(0, "abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state(0, "post_release");
    fmode[0] = 0;
    applyStimulus(0, 0);

    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
